tlk2711_axi_mem_slave: RTL and testbench
========================================

// Module: tlk2711_axi_mem_slave
// PURPOSE
//   Synthesizable AXI4 slave memory responder: the responder end of the tlk2711_top DMA master port.
//   Serves read bursts with a deterministic address-derived pattern and sinks write bursts.
//   Counts traffic and checks the write burst length against WLAST.
//   Used in sim and on-board loopback in place of PS HP0 memory.
// PARAMETERS
//   ADDR_WIDTH  32   AXI address width
//   DATA_WIDTH  128  AXI data width, multiple of 16; lanes L = DATA_WIDTH/16
//   ID_WIDTH    4    AXI ID width; IDs are echoed on RID/BID
// PORTS
//   clk             in   1         single clock, all logic rising-edge
//   rst_n           in   1         asynchronous active-low reset
//   s_axi_arvalid   in   1         read address valid
//   s_axi_arready   out  1         read address ready
//   s_axi_arid      in   ID_WIDTH  read ID
//   s_axi_araddr    in   ADDR_W    read byte address
//   s_axi_arlen     in   8         beats-1
//   s_axi_rvalid    out  1         read data valid
//   s_axi_rready    in   1         read data ready
//   s_axi_rdata     out  DATA_W    pattern data
//   s_axi_rid       out  ID_WIDTH  latched ARID
//   s_axi_rresp     out  2         always 2'b00
//   s_axi_rlast     out  1         last read beat
//   s_axi_awvalid   in   1         write address valid
//   s_axi_awready   out  1         write address ready
//   s_axi_awid      in   ID_WIDTH  write ID
//   s_axi_awaddr    in   ADDR_W    write byte address (accepted; not used for storage)
//   s_axi_awlen     in   8         beats-1
//   s_axi_wvalid    in   1         write data valid
//   s_axi_wready    out  1         write data ready
//   s_axi_wdata     in   DATA_W    write data (sunk)
//   s_axi_wstrb     in   DATA_W/8  byte strobes (ignored)
//   s_axi_wlast     in   1         last write beat
//   s_axi_bvalid    out  1         write response valid
//   s_axi_bready    in   1         write response ready
//   s_axi_bid       out  ID_WIDTH  latched AWID
//   s_axi_bresp     out  2         2'b00 OKAY, 2'b10 SLVERR on WLAST mismatch
//   i_rd_stall      in   1         1 = hold RVALID low (backpressure injection)
//   i_wr_stall      in   1         1 = hold WREADY low
//   o_rd_burst_cnt  out  32        completed read bursts, wraps
//   o_wr_beat_cnt   out  32        accepted write beats, wraps
//   o_wr_err        out  1         sticky: any WLAST mismatch since reset
// BEHAVIOUR
//   Reset (rst_n=0, async): FSMs in idle; RVALID/RLAST/WREADY/BVALID=0; counters and o_wr_err=0.
//   ARREADY/AWREADY=1 in idle state, including during reset.
//   Read FSM, one outstanding burst:
//   - RD_IDLE: ARREADY=1. On ARVALID: latch id, addr, len; beat=0; go to RD_DATA next cycle.
//   - RD_DATA: ARREADY=0; RVALID=!i_rd_stall; RLAST=(beat==len).
//     Beat advances only on RVALID&RREADY; data/RLAST stable while stalled.
//     Last handshake: RD_IDLE, o_rd_burst_cnt+1. First RVALID is 1 cycle after the AR handshake.
//   - Pattern: lane k (bits 16k+15:16k) of beat b = araddr[16:1] + b*L + k, mod 2^16.
//     ARSIZE/ARBURST are ignored; always full-width INCR.
//   Write FSM, independent of read, one outstanding burst:
//   - WR_ADDR: AWREADY=1; WREADY=0. On AWVALID: latch id, len; beat=0; go to WR_DATA.
//   - WR_DATA: WREADY=!i_wr_stall. Each WVALID&WREADY: o_wr_beat_cnt+1, beat+1.
//     The burst ends at the handshake where beat==len (counted length is authoritative).
//     WLAST!=(beat==len) on any handshake sets a burst-local error and o_wr_err (sticky).
//     At burst end go to WR_RESP.
//   - WR_RESP: BVALID=1; BRESP=SLVERR if burst error else OKAY. On BREADY: WR_ADDR, error cleared.
//   - W beats before the AW handshake are not accepted (WREADY=0).
//   Simultaneous read and write activity is fully independent with no arbitration.
//   Reset mid-burst aborts immediately: no further beats and no BVALID for the aborted burst.
// TESTING
//   araddr=0, arlen=15 -> 16 beats; beat0={7,6,5,4,3,2,1,0}; beat1 lanes 8..15; RLAST on beat 15 only; rd_cnt=1.
//   araddr=0x20, arlen=0, i_rd_stall toggling -> single beat lane0=0x10; data/RLAST held during stall.
//   awlen=3, 4 beats, WLAST on 4th -> BRESP=OKAY, BID=AWID, wr_beat_cnt=4, o_wr_err=0.
//   awlen=3, WLAST on 3rd beat -> burst still ends after 4 beats; BRESP=2'b10; o_wr_err=1 stays set.
//   Concurrent 16-beat read and write with RREADY/BREADY random -> both complete; counters 1 and 16.
//   rst_n low mid-read (beat 5 of 16) -> RVALID=0 at once; ARREADY=1; next burst restarts at beat 0.

Source files
------------

// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 slave memory responder for the tlk2711_top DMA port: serves reads with an
// address-derived 16-bit lane pattern, sinks writes, and checks WLAST against the burst length.
module tlk2711_axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    i_rd_stall,
  input  logic                    i_wr_stall,
  output logic [31:0]             o_rd_burst_cnt,
  output logic [31:0]             o_wr_beat_cnt,
  output logic                    o_wr_err
);

  localparam int LANES = DATA_WIDTH / 16;

  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t rd_state, rd_state_next;
  wr_state_t wr_state, wr_state_next;

  logic [ID_WIDTH-1:0] rd_id, wr_id;
  logic [15:0]         rd_base;
  logic [7:0]          rd_len, rd_beat, wr_len, wr_beat;
  logic                rd_fire, wr_fire, wr_burst_err;
  logic [15:0]         beat_base;

  // Storage is never modelled, so write address/data/strobes and the address bits
  // outside the pattern window are intentionally left unused.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr, s_axi_wdata, s_axi_wstrb,
                           s_axi_araddr[ADDR_WIDTH-1:17], s_axi_araddr[0]};

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_ADDR;
    end else begin
      rd_state <= rd_state_next;
      wr_state <= wr_state_next;
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    rd_state_next = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    rd_fire       = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) rd_state_next = RD_DATA;
      end
      RD_DATA: begin
        s_axi_rvalid = !i_rd_stall;
        s_axi_rlast  = (rd_beat == rd_len);
        rd_fire      = !i_rd_stall && s_axi_rready;
        if (rd_fire && (rd_beat == rd_len)) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_next = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_fire       = 1'b0;
    case (wr_state)
      WR_ADDR: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) wr_state_next = WR_DATA;
      end
      WR_DATA: begin
        s_axi_wready = !i_wr_stall;
        wr_fire      = s_axi_wvalid && !i_wr_stall;
        if (wr_fire && (wr_beat == wr_len)) wr_state_next = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_next = WR_ADDR;
      end
      default: wr_state_next = WR_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_id          <= '0;
      rd_base        <= '0;
      rd_len         <= '0;
      rd_beat        <= '0;
      o_rd_burst_cnt <= '0;
    end else if (rd_state == RD_IDLE && s_axi_arvalid) begin
      rd_id   <= s_axi_arid;
      rd_base <= s_axi_araddr[16:1];
      rd_len  <= s_axi_arlen;
      rd_beat <= '0;
    end else if (rd_fire) begin
      if (rd_beat == rd_len) o_rd_burst_cnt <= o_rd_burst_cnt + 32'd1;
      else                   rd_beat        <= rd_beat + 8'd1;
    end
  end

  // The counted length ends the burst; WLAST is only compared against it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_id         <= '0;
      wr_len        <= '0;
      wr_beat       <= '0;
      wr_burst_err  <= 1'b0;
      o_wr_beat_cnt <= '0;
      o_wr_err      <= 1'b0;
    end else begin
      if (wr_state == WR_ADDR && s_axi_awvalid) begin
        wr_id   <= s_axi_awid;
        wr_len  <= s_axi_awlen;
        wr_beat <= '0;
      end
      if (wr_fire) begin
        o_wr_beat_cnt <= o_wr_beat_cnt + 32'd1;
        wr_beat       <= wr_beat + 8'd1;
        if (s_axi_wlast != (wr_beat == wr_len)) begin
          wr_burst_err <= 1'b1;
          o_wr_err     <= 1'b1;
        end
      end
      if (wr_state == WR_RESP && s_axi_bready) wr_burst_err <= 1'b0;
    end
  end

  always_comb begin
    beat_base   = rd_base + 16'(rd_beat) * 16'(LANES);
    s_axi_rdata = '0;
    for (int k = 0; k < LANES; k++) s_axi_rdata[16*k +: 16] = beat_base + 16'(k);
  end

  assign s_axi_rid   = rd_id;
  assign s_axi_rresp = 2'b00;
  assign s_axi_bid   = wr_id;
  assign s_axi_bresp = wr_burst_err ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Self-checking bench for tlk2711_axi_mem_slave: a transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_tlk2711_axi_mem_slave;

  logic         clk, rst_n;
  logic         s_axi_arvalid, s_axi_arready;
  logic [3:0]   s_axi_arid;
  logic [31:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] s_axi_rdata;
  logic [3:0]   s_axi_rid;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_awvalid, s_axi_awready;
  logic [3:0]   s_axi_awid;
  logic [31:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic         s_axi_wvalid, s_axi_wready;
  logic [127:0] s_axi_wdata;
  logic [15:0]  s_axi_wstrb;
  logic         s_axi_wlast;
  logic         s_axi_bvalid, s_axi_bready;
  logic [3:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         i_rd_stall, i_wr_stall;
  logic [31:0]  o_rd_burst_cnt, o_wr_beat_cnt;
  logic         o_wr_err;

  int n_pass  = 0;
  int n_total = 0;

  tlk2711_axi_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .i_rd_stall(i_rd_stall), .i_wr_stall(i_wr_stall),
    .o_rd_burst_cnt(o_rd_burst_cnt), .o_wr_beat_cnt(o_wr_beat_cnt), .o_wr_err(o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beat: lane k holds (byte address / 2) + beat * 8 + k, truncated to 16 bits.
  function automatic logic [127:0] pattern(input logic [31:0] addr, input int beat);
    logic [127:0] r;
    int v;
    for (int k = 0; k < 8; k++) begin
      v = int'(addr >> 1) + beat * 8 + k;
      r[16*k +: 16] = v[15:0];
    end
    return r;
  endfunction

  // Transaction-level model of the responder.
  bit          m_rd_busy = 0;
  logic [31:0] m_rd_addr = '0;
  logic [3:0]  m_rd_id = '0, m_wr_id = '0;
  int          m_rd_len = 0, m_rd_beat = 0, m_rd_cnt = 0;
  int          m_wr_left = 0, m_wr_beats = 0;
  bit          m_b_pending = 0, m_err_burst = 0, m_err_sticky = 0;
  bit          cmp_en = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd_busy = 0; m_rd_addr = '0; m_rd_id = '0; m_rd_len = 0; m_rd_beat = 0; m_rd_cnt = 0;
      m_wr_id = '0; m_wr_left = 0; m_wr_beats = 0;
      m_b_pending = 0; m_err_burst = 0; m_err_sticky = 0;
    end else begin
      if (!m_rd_busy) begin
        if (s_axi_arvalid) begin
          m_rd_busy = 1; m_rd_addr = s_axi_araddr; m_rd_id = s_axi_arid;
          m_rd_len = int'(s_axi_arlen); m_rd_beat = 0;
        end
      end else if (!i_rd_stall && s_axi_rready) begin
        if (m_rd_beat == m_rd_len) begin
          m_rd_busy = 0;
          m_rd_cnt++;
        end else m_rd_beat++;
      end

      if (m_wr_left == 0 && !m_b_pending) begin
        if (s_axi_awvalid) begin
          m_wr_left = int'(s_axi_awlen) + 1;
          m_wr_id   = s_axi_awid;
        end
      end else if (m_wr_left > 0) begin
        if (s_axi_wvalid && !i_wr_stall) begin
          m_wr_beats++;
          if (s_axi_wlast != (m_wr_left == 1)) begin
            m_err_burst  = 1;
            m_err_sticky = 1;
          end
          m_wr_left--;
          if (m_wr_left == 0) m_b_pending = 1;
        end
      end else if (s_axi_bready) begin
        m_b_pending = 0;
        m_err_burst = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("arready", s_axi_arready, !m_rd_busy);
      check("rvalid", s_axi_rvalid, m_rd_busy && !i_rd_stall);
      if (m_rd_busy) begin
        check("rdata", s_axi_rdata, pattern(m_rd_addr, m_rd_beat));
        check("rlast", s_axi_rlast, m_rd_beat == m_rd_len);
        check("rid", s_axi_rid, m_rd_id);
        check("rresp", s_axi_rresp, 2'b00);
      end
      check("awready", s_axi_awready, m_wr_left == 0 && !m_b_pending);
      check("wready", s_axi_wready, m_wr_left > 0 && !i_wr_stall);
      check("bvalid", s_axi_bvalid, m_b_pending);
      if (m_b_pending) begin
        check("bresp", s_axi_bresp, m_err_burst ? 2'b10 : 2'b00);
        check("bid", s_axi_bid, m_wr_id);
      end
      check("rd_burst_cnt", o_rd_burst_cnt, 32'(m_rd_cnt));
      check("wr_beat_cnt", o_wr_beat_cnt, 32'(m_wr_beats));
      check("wr_err", o_wr_err, m_err_sticky);
    end
  end

  initial begin
    int  sent, cyc;
    bit  hs, done;
    rst_n = 1'b0;
    s_axi_arvalid = 0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_rready = 0;
    s_axi_awvalid = 0; s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '1; s_axi_wlast = 0; s_axi_bready = 0;
    i_rd_stall = 0; i_wr_stall = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", s_axi_arready, 1'b1);
    check("rst_awready", s_axi_awready, 1'b1);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_cnts", {o_rd_burst_cnt, o_wr_beat_cnt, 31'd0, o_wr_err}, '0);
    rst_n = 1'b1;
    step();

    // 16-beat read from address 0
    s_axi_araddr = 32'h0; s_axi_arlen = 8'd15; s_axi_arid = 4'h2; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0;
    check("rd_beat0", s_axi_rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("rd_rid", s_axi_rid, 4'h2);
    s_axi_rready = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) check("rd_beat1", s_axi_rdata, 128'h000f_000e_000d_000c_000b_000a_0009_0008);
      check("rd_rlast_pos", s_axi_rlast, i == 15);
      check("rd_rvalid_on", s_axi_rvalid, 1'b1);
      step();
    end
    check("rd_cnt_1", o_rd_burst_cnt, 32'd1);
    check("rd_idle_after", s_axi_arready, 1'b1);

    // single beat with stall toggling; data and RLAST must hold
    i_rd_stall = 1; s_axi_rready = 0;
    s_axi_araddr = 32'h20; s_axi_arlen = 8'd0; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0;
    for (int j = 0; j < 4; j++) begin
      i_rd_stall = (j % 2 == 0);
      #1;
      check("stall_rvalid", s_axi_rvalid, j % 2 != 0);
      check("stall_lane0", s_axi_rdata[15:0], 16'h0010);
      check("stall_rlast", s_axi_rlast, 1'b1);
      step();
    end
    i_rd_stall = 0; s_axi_rready = 1;
    #1;
    check("stall_release", s_axi_rvalid, 1'b1);
    step();
    check("rd_cnt_2", o_rd_burst_cnt, 32'd2);

    // good 4-beat write; early WVALID must not be accepted before AW
    s_axi_awid = 4'h5; s_axi_awlen = 8'd3; s_axi_awaddr = 32'h1000; s_axi_awvalid = 1;
    s_axi_wvalid = 1;
    #1;
    check("w_before_aw", s_axi_wready, 1'b0);
    step();
    s_axi_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      s_axi_wlast = (i == 3); s_axi_wdata = 128'(i);
      #1;
      check("wr_ready_on", s_axi_wready, 1'b1);
      step();
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    check("wr_ok_bvalid", s_axi_bvalid, 1'b1);
    check("wr_ok_bresp", s_axi_bresp, 2'b00);
    check("wr_ok_bid", s_axi_bid, 4'h5);
    check("wr_ok_cnt", o_wr_beat_cnt, 32'd4);
    check("wr_ok_err", o_wr_err, 1'b0);
    s_axi_bready = 1;
    step();
    s_axi_bready = 0;
    check("wr_ok_done", s_axi_awready, 1'b1);

    // WLAST on 3rd beat of 4: burst still runs 4 beats, SLVERR, sticky error
    s_axi_awid = 4'h6; s_axi_awvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s_axi_wlast = (i == 2);
      if (i == 3) check("wr_no_early_end", s_axi_bvalid, 1'b0);
      step();
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    check("wr_bad_bresp", s_axi_bresp, 2'b10);
    check("wr_bad_bid", s_axi_bid, 4'h6);
    check("wr_bad_cnt", o_wr_beat_cnt, 32'd8);
    check("wr_bad_err", o_wr_err, 1'b1);
    s_axi_bready = 1;
    step();
    s_axi_bready = 0;
    check("wr_err_sticky", o_wr_err, 1'b1);

    // concurrent 16-beat read and write with random handshakes
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd15; s_axi_arid = 4'h3; s_axi_arvalid = 1;
    s_axi_awid = 4'h9; s_axi_awlen = 8'd15; s_axi_awvalid = 1;
    step();
    s_axi_arvalid = 0; s_axi_awvalid = 0;
    sent = 0; cyc = 0; done = 0;
    while (!done && cyc < 400) begin
      s_axi_rready = 1'($urandom_range(0, 1));
      s_axi_bready = 1'($urandom_range(0, 1));
      i_rd_stall   = ($urandom_range(0, 3) == 0);
      i_wr_stall   = ($urandom_range(0, 3) == 0);
      s_axi_wvalid = (sent < 16) && ($urandom_range(0, 3) != 0);
      s_axi_wlast  = (sent == 15);
      s_axi_wdata  = {4{$urandom}};
      #1;
      hs = s_axi_wvalid && s_axi_wready;
      @(posedge clk);
      #1;
      if (hs) sent++;
      cyc++;
      done = !m_rd_busy && m_wr_left == 0 && !m_b_pending;
    end
    s_axi_rready = 0; s_axi_bready = 0; s_axi_wvalid = 0; s_axi_wlast = 0;
    i_rd_stall = 0; i_wr_stall = 0;
    check("conc_done", done, 1'b1);
    check("conc_rd_cnt", o_rd_burst_cnt, 32'd3);
    check("conc_wr_cnt", o_wr_beat_cnt, 32'd24);
    check("conc_err_sticky", o_wr_err, 1'b1);

    // reset in the middle of a read burst
    s_axi_araddr = 32'h0; s_axi_arlen = 8'd15; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0; s_axi_rready = 1;
    repeat (5) step();
    check("pre_rst_beat5", s_axi_rdata[15:0], 16'd40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", s_axi_rvalid, 1'b0);
    check("mid_rst_rlast", s_axi_rlast, 1'b0);
    check("mid_rst_arready", s_axi_arready, 1'b1);
    check("mid_rst_cnt", o_rd_burst_cnt, 32'd0);
    check("mid_rst_err", o_wr_err, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    s_axi_araddr = 32'h40; s_axi_arlen = 8'd1; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0;
    check("restart_beat0", s_axi_rdata, 128'h0027_0026_0025_0024_0023_0022_0021_0020);
    check("restart_rlast", s_axi_rlast, 1'b0);
    step();
    step();
    check("restart_cnt", o_rd_burst_cnt, 32'd1);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
